// File: rtl/dogx_sample_serializer.sv
// DOGX output link transmitter: buffers {alpha, sample} words in a small FIFO and
// serializes each as an 8-slot frame (sync, six 2-lane data slots, per-lane parity).
module dogx_sample_serializer #(
    parameter int DATA_W     = 11,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                               CLK_24M,
    input  logic                               reset,
    input  logic                               sample_valid,
    input  logic signed [DATA_W-1:0]           sample_data,
    input  logic                               sample_alpha,
    input  logic                               enable_tx,
    input  logic                               clear_overflow,
    output logic                               frame_sync,
    output logic [1:0]                         sdata,
    output logic                               overflow_sticky,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int WORD_W = DATA_W + 1;
    localparam int LANE_W = WORD_W / 2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0] LAST_SLOT = 3'(LANE_W);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    // Picks every other bit of the word; odd=1 gives lane 0, odd=0 gives lane 1, MSB first.
    function automatic logic [LANE_W-1:0] lane_bits(input logic [WORD_W-1:0] w, input logic odd);
        logic [LANE_W-1:0] r;
        for (int i = 0; i < LANE_W; i++) begin
            r[i] = w[2*i + int'(odd)];
        end
        return r;
    endfunction

    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [WORD_W-1:0] head_word;
    logic              fifo_empty, fifo_full, push, pop, drop;

    state_t            state, state_nxt;
    logic [2:0]        slot, slot_nxt;
    logic              shift, frame_sync_nxt;
    logic [1:0]        sdata_nxt;
    logic [LANE_W-1:0] lane0_sr, lane1_sr;
    logic [1:0]        lane_par;

    assign head_word  = fifo_mem[rd_ptr];
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push       = sample_valid && (!fifo_full || pop);
    assign drop       = sample_valid && fifo_full && !pop;

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_level      <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
            if (drop)
                overflow_sticky <= 1'b1;
            else if (clear_overflow)
                overflow_sticky <= 1'b0;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (push) fifo_mem[wr_ptr] <= {sample_alpha, sample_data};
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        slot_nxt       = slot;
        pop            = 1'b0;
        shift          = 1'b0;
        frame_sync_nxt = 1'b0;
        sdata_nxt      = 2'b00;
        case (state)
            IDLE, PARITY: begin
                if (enable_tx && !fifo_empty) begin
                    state_nxt      = SYNC;
                    pop            = 1'b1;
                    frame_sync_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SYNC: begin
                state_nxt = DATA;
                slot_nxt  = 3'd1;
                sdata_nxt = {lane1_sr[LANE_W-1], lane0_sr[LANE_W-1]};
                shift     = 1'b1;
            end
            DATA: begin
                if (slot == LAST_SLOT) begin
                    state_nxt = PARITY;
                    sdata_nxt = lane_par;
                end else begin
                    slot_nxt  = slot + 3'd1;
                    sdata_nxt = {lane1_sr[LANE_W-1], lane0_sr[LANE_W-1]};
                    shift     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word is split into lanes and its parity precomputed at pop time.
    always_ff @(posedge CLK_24M) begin
        if (pop) begin
            lane0_sr <= lane_bits(head_word, 1'b1);
            lane1_sr <= lane_bits(head_word, 1'b0);
            lane_par <= {^lane_bits(head_word, 1'b0), ^lane_bits(head_word, 1'b1)};
        end else if (shift) begin
            lane0_sr <= lane0_sr << 1;
            lane1_sr <= lane1_sr << 1;
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            frame_sync <= 1'b0;
            sdata      <= 2'b00;
        end else begin
            frame_sync <= frame_sync_nxt;
            sdata      <= sdata_nxt;
        end
    end

endmodule

// File: tb/tb_dogx_sample_serializer.sv
// Directed bench for dogx_sample_serializer: a frame monitor decodes every frame
// against a queue of expected words while the main sequence drives scenarios.
module tb_dogx_sample_serializer;

    logic        CLK_24M;
    logic        reset;
    logic        sample_valid;
    logic [10:0] sample_data;
    logic        sample_alpha;
    logic        enable_tx;
    logic        clear_overflow;
    logic        frame_sync;
    logic [1:0]  sdata;
    logic        overflow_sticky;
    logic [1:0]  fifo_level;

    dogx_sample_serializer #(.DATA_W(11), .FIFO_DEPTH(2)) dut (
        .CLK_24M        (CLK_24M),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .sample_alpha   (sample_alpha),
        .enable_tx      (enable_tx),
        .clear_overflow (clear_overflow),
        .frame_sync     (frame_sync),
        .sdata          (sdata),
        .overflow_sticky(overflow_sticky),
        .fifo_level     (fifo_level)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int frames_rx = 0;
    logic [11:0] exp_q[$];
    int          sync_q[$];
    logic [1:0]  last_par;

    initial CLK_24M = 1'b0;
    always #5 CLK_24M = ~CLK_24M;
    always @(posedge CLK_24M) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge CLK_24M);
    endtask

    task automatic check_periods(input string tag, input int n_exp);
        int bad = 0;
        chk({tag, "_nsync"}, sync_q.size(), n_exp);
        for (int i = 1; i < sync_q.size(); i++)
            if (sync_q[i] - sync_q[i-1] != 8) bad++;
        chk({tag, "_period"}, bad, 0);
    endtask

    // Frame monitor: decodes lanes back into words and checks parity per lane.
    initial begin
        int          mon_cnt;
        logic [11:0] mon_w;
        logic [31:0] exp_w;
        logic        p0, p1;
        mon_cnt = 0;
        mon_w   = '0;
        forever begin
            @(negedge CLK_24M);
            if (!reset) begin
                mon_cnt = 0;
                exp_q.delete();
            end else if (mon_cnt == 0) begin
                if (frame_sync) begin
                    mon_cnt = 1;
                    sync_q.push_back(cyc);
                    chk("mon_sync_sdata", 32'(sdata), 0);
                end
            end else if (mon_cnt <= 6) begin
                chk("mon_fs_low", 32'(frame_sync), 0);
                mon_w[13 - 2*mon_cnt] = sdata[0];
                mon_w[12 - 2*mon_cnt] = sdata[1];
                mon_cnt++;
            end else begin
                p0 = 1'b0;
                p1 = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    p0 = p0 ^ mon_w[2*i + 1];
                    p1 = p1 ^ mon_w[2*i];
                end
                last_par = sdata;
                chk("mon_fs_low_par", 32'(frame_sync), 0);
                chk("mon_parity", 32'(sdata), 32'({p1, p0}));
                if (exp_q.size() != 0) exp_w = 32'(exp_q.pop_front());
                else                   exp_w = 32'hDEAD_0000;
                chk("mon_word", 32'(mon_w), exp_w);
                frames_rx++;
                mon_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] w;
        logic [6:0]  l0_exp, l1_exp;
        int          f0, maxlvl, n;

        reset = 1'b0;
        sample_valid = 1'b0;
        sample_data = '0;
        sample_alpha = 1'b0;
        enable_tx = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) tick();
        chk("rst_fs", 32'(frame_sync), 0);
        chk("rst_sdata", 32'(sdata), 0);
        chk("rst_ovf", 32'(overflow_sticky), 0);
        chk("rst_level", 32'(fifo_level), 0);
        reset = 1'b1;
        tick();

        // Single sample W=DA3, lanes hand-decoded (last bit is parity).
        l0_exp = 7'b1011010;
        l1_exp = 7'b1100011;
        enable_tx = 1'b1;
        f0 = frames_rx;
        exp_q.push_back(12'hDA3);
        sample_valid = 1'b1;
        sample_data  = 11'h5A3;
        sample_alpha = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("t1_level_after_push", 32'(fifo_level), 1);
        tick();
        chk("t1_sync", 32'(frame_sync), 1);
        chk("t1_sync_sdata", 32'(sdata), 0);
        chk("t1_level_after_pop", 32'(fifo_level), 0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t1_fs_low", 32'(frame_sync), 0);
            chk($sformatf("t1_slot%0d", k + 1), 32'(sdata), 32'({l1_exp[6-k], l0_exp[6-k]}));
        end
        repeat (4) begin
            tick();
            chk("t1_idle_fs", 32'(frame_sync), 0);
            chk("t1_idle_sdata", 32'(sdata), 0);
        end
        chk("t1_frames", frames_rx - f0, 1);
        chk("t1_parity", 32'(last_par), 32'(2'b10));

        // Stream of 16 samples, one every 8 cycles.
        sync_q.delete();
        f0 = frames_rx;
        maxlvl = 0;
        for (int i = 0; i < 16; i++) begin
            w = 12'($urandom_range(0, 4095));
            exp_q.push_back(w);
            sample_valid = 1'b1;
            {sample_alpha, sample_data} = w;
            tick();
            sample_valid = 1'b0;
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            repeat (7) begin
                tick();
                if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            end
        end
        repeat (12) tick();
        chk("t2_frames", frames_rx - f0, 16);
        check_periods("t2", 16);
        chk("t2_ovf", 32'(overflow_sticky), 0);
        chk("t2_maxlvl", maxlvl, 1);

        // Three pushes with tx disabled; third drops, clear on same edge loses.
        enable_tx = 1'b0;
        f0 = frames_rx;
        exp_q.push_back(12'h123);
        exp_q.push_back(12'hABC);
        sample_valid = 1'b1;
        {sample_alpha, sample_data} = 12'h123;
        tick();
        chk("t3_level1", 32'(fifo_level), 1);
        {sample_alpha, sample_data} = 12'hABC;
        tick();
        chk("t3_level2", 32'(fifo_level), 2);
        chk("t3_ovf_before", 32'(overflow_sticky), 0);
        {sample_alpha, sample_data} = 12'h777;
        clear_overflow = 1'b1;
        tick();
        sample_valid = 1'b0;
        clear_overflow = 1'b0;
        chk("t3_level_full", 32'(fifo_level), 2);
        chk("t5_set_wins", 32'(overflow_sticky), 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("t5_cleared", 32'(overflow_sticky), 0);
        repeat (3) tick();
        chk("t3_no_frame_disabled", frames_rx - f0, 0);
        chk("t3_fs_disabled", 32'(frame_sync), 0);
        sync_q.delete();
        enable_tx = 1'b1;
        repeat (20) tick();
        chk("t3_frames", frames_rx - f0, 2);
        check_periods("t3", 2);
        chk("t3_level_end", 32'(fifo_level), 0);

        // enable_tx dropped at slot 3 with another word waiting.
        f0 = frames_rx;
        exp_q.push_back(12'h9C5);
        sample_valid = 1'b1;
        {sample_alpha, sample_data} = 12'h9C5;
        tick();
        sample_valid = 1'b0;
        tick();
        chk("t4_sync", 32'(frame_sync), 1);
        sample_valid = 1'b1;
        {sample_alpha, sample_data} = 12'h3E1;
        tick();
        sample_valid = 1'b0;
        chk("t4_level_queued", 32'(fifo_level), 1);
        repeat (2) tick();
        enable_tx = 1'b0;
        repeat (15) tick();
        chk("t4_frames", frames_rx - f0, 1);
        chk("t4_level_held", 32'(fifo_level), 1);
        chk("t4_idle_fs", 32'(frame_sync), 0);
        chk("t4_idle_sdata", 32'(sdata), 0);

        // Reset at slot 4 with one word queued.
        f0 = frames_rx;
        exp_q.push_back(12'h3E1);
        enable_tx = 1'b1;
        n = 0;
        while (!frame_sync && n < 10) begin
            tick();
            n++;
        end
        chk("t6_sync_seen", 32'(frame_sync), 1);
        sample_valid = 1'b1;
        {sample_alpha, sample_data} = 12'h5F0;
        tick();
        sample_valid = 1'b0;
        repeat (3) tick();
        chk("t6_level_pre", 32'(fifo_level), 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_fs", 32'(frame_sync), 0);
        chk("t6_rst_sdata", 32'(sdata), 0);
        chk("t6_rst_level", 32'(fifo_level), 0);
        chk("t6_rst_ovf", 32'(overflow_sticky), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (15) tick();
        chk("t6_no_frame", frames_rx - f0, 0);
        chk("t6_level_post", 32'(fifo_level), 0);
        exp_q.push_back(12'h0F7);
        sample_valid = 1'b1;
        {sample_alpha, sample_data} = 12'h0F7;
        tick();
        sample_valid = 1'b0;
        repeat (12) tick();
        chk("t6_new_frame", frames_rx - f0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dogx_sample_serializer.md
# dogx_sample_serializer

Transmit side of the DOGX converter output link. Takes the 11-bit converter sample and its alpha flag at the 3 MHz sample rate and serializes them onto a 2-lane, 8-cycle framed link clocked by CLK_24M. The link carries a sync slot, six data slots and a parity slot. A 2-entry FIFO absorbs phase jitter between sample arrival and frame boundaries. A sticky overflow flag reports dropped samples.

## Interface
- DATA_W, 11, converter sample width; the transmitted word is DATA_W+1 = 12 bits, formed as {alpha, data}.
- FIFO_DEPTH, 2, sample FIFO depth in entries; power of two, at least 2.
- CLK_24M  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low.
- sample_valid  in  1  sample strobe, one cycle per sample; normally driven by the 3 MHz sampling enable.
- sample_data  in  DATA_W  converter sample, two's complement; passed through unmodified.
- sample_alpha  in  1  alpha flag associated with the sample.
- enable_tx  in  1  allows new frames to start.
- clear_overflow  in  1  clears overflow_sticky.
- frame_sync  out  1  high during the sync slot of each frame.
- sdata  out  2  serial lanes; sdata[0] is lane 0 and sdata[1] is lane 1.
- overflow_sticky  out  1  set when a sample is dropped.
- fifo_level  out  2  current FIFO occupancy, 0..2.

## Operation
- Word W[11:0] = {sample_alpha, sample_data}.
- Lane 0 carries the odd bits of W, MSB first: W11, W9, W7, W5, W3, W1.
- Lane 1 carries the even bits of W, MSB first: W10, W8, W6, W4, W2, W0.
- Frame = 8 slots, one per CLK_24M cycle:
  - slot 0 (SYNC): frame_sync=1, sdata=2'b00.
  - slots 1-6 (DATA): one bit per lane per slot, in the order above.
  - slot 7 (PARITY): each lane carries the XOR of its own six data bits (even parity per lane).
- FSM states: IDLE, SYNC, DATA (3-bit slot counter 1..6), PARITY.
  - IDLE→SYNC when enable_tx=1 and the FIFO is non-empty. The FIFO is popped on this transition and the word is loaded into the lane shift registers.
  - SYNC→DATA unconditionally.
  - DATA→PARITY after slot 6.
  - PARITY→SYNC when enable_tx=1 and the FIFO is non-empty (back-to-back frame, with a pop). Otherwise PARITY→IDLE.
- In IDLE: frame_sync=0, sdata=2'b00.
- All outputs are registered.
- FIFO push: on any edge where sample_valid=1.
  - If the FIFO is full and no pop occurs on the same edge, the sample is discarded and overflow_sticky is set.
  - Push and pop on the same edge while full is legal: no drop, level unchanged.
  - Push and pop on the same edge while empty is not possible, because a pop requires level ≥ 1 before the edge.
- enable_tx=0 mid-frame: the current frame completes through PARITY, then the FSM goes to IDLE. The FIFO continues to accept pushes, and overflow can occur.
- overflow_sticky: set by a drop, cleared by clear_overflow. If both occur on the same edge, set wins.
- The data path performs no arithmetic; bits are passed through unchanged.

## Timing
- Reset values: frame_sync=0, sdata=2'b00, overflow_sticky=0, fifo_level=0, FSM in IDLE, FIFO empty.
- Assertion of reset mid-frame aborts the frame immediately and flushes the FIFO. The first frame after release requires a new sample.
- Latency, with sample_valid sampled high at edge N while IDLE, FIFO empty and enable_tx=1:
  - fifo_level=1 after edge N.
  - frame_sync=1 after edge N+1, and fifo_level returns to 0.
  - Data slots follow edges N+2..N+7.
  - Parity follows edge N+8.
- Back-to-back: the next frame_sync follows edge N+9, exactly 8 cycles after the previous one. There are no idle gaps while the FIFO is non-empty.
- Sustained input of 1 sample per 8 cycles keeps fifo_level ≤ 1 with no overflow.
- Sustained input faster than 1 sample per 8 cycles overflows.

## Test plan
- Single sample, data=11'h5A3, alpha=1 (W=12'hDA3):
  - frame_sync pulses once for 1 cycle.
  - lane 0 = 1,0,1,1,0,1 then parity 0.
  - lane 1 = 1,1,0,0,0,1 then parity 1.
  - FSM returns to IDLE and sdata=00.
- Stream of 16 random samples, one every 8 cycles: frame_sync has a period of exactly 8, all words decode correctly in order, overflow_sticky stays 0, and fifo_level never exceeds 1.
- enable_tx=0 while 3 samples are pushed 1 cycle apart:
  - fifo_level reaches 2 and the third push sets overflow_sticky.
  - On raising enable_tx, exactly 2 back-to-back frames carrying the first two words are sent.
- enable_tx dropped at slot 3: the current frame completes with correct parity, then the FSM stays IDLE even though fifo_level=1.
- clear_overflow asserted on the same edge as a drop: overflow_sticky stays 1. clear_overflow asserted alone on a later edge: overflow_sticky goes to 0.
- reset asserted at slot 4 with fifo_level=1: all outputs go to their reset values immediately, and no frame is sent after release until a new sample_valid arrives.
